// File: rtl/fx_arb_pkg.sv
// fx_arb_pkg: shared state type and constants for the fx_opt sharing arbiter
package fx_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_t;
  localparam logic [31:0] FX_QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fx_share_arb_if.sv
// fx_share_arb_if: requester, response and engine pins of the fx_opt sharing arbiter
interface fx_share_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ-1:0][31:0] req_x;
  logic [31:0] rsp_data, eng_x, eng_fx;
  logic rsp_err, eng_start, eng_done;
  modport slave (
    input req_valid, req_x, rsp_ready, eng_done, eng_fx,
    output req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_x
  );
  modport master (
    output req_valid, req_x, rsp_ready, eng_done, eng_fx,
    input req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_x
  );
endinterface

// File: rtl/fx_share_arb_rr_pick.sv
// rr_pick: first valid index at or after ptr, wrapping modulo N, as one-hot grant and index
module rr_pick #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input logic [N-1:0] valid,
  input logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic any
);
  always_comb begin
    idx = '0;
    // scan farthest-first so the nearest valid index after ptr is the last one written
    for (int i = N - 1; i >= 0; i--)
      if (valid[(int'(ptr) + i) % N]) idx = W'((int'(ptr) + i) % N);
    any = |valid;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/fx_share_arb.sv
// fx_share_arb: round-robin sequencer sharing one fx_opt engine among NUM_REQ requesters, with watchdog
module fx_share_arb
  import fx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic reset,
  input logic clk_en,
  fx_share_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  arb_state_t state, nxt;
  logic [PW-1:0] rr_ptr, owner, idx;
  logic [NUM_REQ-1:0] grant, rsp_vld;
  logic [31:0] x_reg, rsp_reg;
  logic [WW-1:0] wd;
  logic any, err, wd_hit, finish;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid(bus.req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  assign wd_hit = wd == WW'(TIMEOUT_CYCLES - 1);
  assign finish = bus.eng_done || wd_hit;
  // grant is withheld while frozen or in reset so a handshake never completes unregistered
  assign bus.req_ready = (state == IDLE && clk_en && !reset) ? grant : '0;
  assign bus.eng_start = state == ISSUE && clk_en;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data = rsp_reg;
  assign bus.rsp_err = err;
  assign bus.eng_x = x_reg;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = any ? ISSUE : IDLE;
      ISSUE: nxt = BUSY;
      BUSY: nxt = finish ? RESP : BUSY;
      RESP: nxt = bus.rsp_ready[owner] ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      x_reg <= '0;
      rsp_reg <= '0;
      err <= 1'b0;
      wd <= '0;
      rsp_vld <= '0;
    end else if (clk_en) begin
      state <= nxt;
      if (state == IDLE && any) begin
        x_reg <= bus.req_x[idx];
        owner <= idx;
      end
      wd <= state == ISSUE ? '0 : (state == BUSY && !wd_hit) ? wd + 1'b1 : wd;
      // a done strobe in the watchdog's last cycle still delivers the real result
      if (state == BUSY && finish) begin
        rsp_reg <= bus.eng_done ? bus.eng_fx : FX_QNAN;
        err <= !bus.eng_done;
        rsp_vld <= NUM_REQ'(1) << owner;
      end
      if (state == RESP && bus.rsp_ready[owner]) begin
        rr_ptr <= owner == PW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
        rsp_vld <= '0;
      end
    end
endmodule

// File: tb/tb_fx_share_arb.sv
// tb_fx_share_arb: directed checks of fx_share_arb; u_main uses the default watchdog, u_tmo a 16-cycle one
module tb_fx_share_arb;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1;
  int checks = 0, failures = 0;
  logic [31:0] bad;
  fx_share_arb_if #(.NUM_REQ(2)) a ();
  fx_share_arb_if #(.NUM_REQ(2)) b ();
  fx_share_arb #(.NUM_REQ(2), .TIMEOUT_CYCLES(256)) u_main (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(a.slave)
  );
  fx_share_arb #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) u_tmo (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(b.slave)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    a.req_valid = '0; a.req_x = '0; a.rsp_ready = '0; a.eng_done = 1'b0; a.eng_fx = '0;
    b.req_valid = '0; b.req_x = '0; b.rsp_ready = '0; b.eng_done = 1'b0; b.eng_fx = '0;
    cyc(2);
    chk("rst_req_ready", 32'(a.req_ready), 0);
    chk("rst_rsp_valid", 32'(a.rsp_valid), 0);
    chk("rst_eng_start", 32'(a.eng_start), 0);
    chk("rst_rsp_data", a.rsp_data, 0);
    chk("rst_rsp_err", 32'(a.rsp_err), 0);
    chk("rst_eng_x", a.eng_x, 0);
    reset = 1'b0;
    // single request, L = 20: start at cycle 1, done at 21, response at 22
    a.req_valid = 2'b01; a.req_x[0] = 32'h43000000;
    #1 chk("single_grant", 32'(a.req_ready), 1);
    cyc(1); a.req_valid = '0;
    chk("single_start", 32'(a.eng_start), 1);
    chk("single_eng_x", a.eng_x, 32'h43000000);
    bad = 0;
    for (int c = 2; c <= 21; c++) begin
      cyc(1);
      if (a.eng_start || a.rsp_valid != 0 || a.req_ready != 0) bad++;
    end
    chk("single_quiet", bad, 0);
    a.eng_done = 1'b1; a.eng_fx = 32'h46808000;
    cyc(1); a.eng_done = 1'b0;
    chk("single_rsp_valid", 32'(a.rsp_valid), 1);
    chk("single_rsp_data", a.rsp_data, 32'h46808000);
    chk("single_rsp_err", 32'(a.rsp_err), 0);
    a.rsp_ready = 2'b01;
    cyc(1);
    chk("single_release", 32'(a.rsp_valid), 0);
    // fairness from a fresh pointer, L = 1
    reset = 1'b1; cyc(1); reset = 1'b0;
    a.req_valid = 2'b11; a.req_x = '0; a.rsp_ready = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("fair_grant%0d", t), 32'(a.req_ready), (t % 2) ? 2 : 1);
      cyc(2); a.eng_done = 1'b1; a.eng_fx = '0;
      cyc(1); a.eng_done = 1'b0;
      chk($sformatf("fair_rsp%0d", t), 32'(a.rsp_valid), (t % 2) ? 2 : 1);
      chk($sformatf("fair_data%0d", t), a.rsp_data, 0);
      cyc(1);
    end
    a.req_valid = '0; a.rsp_ready = '0;
    // backpressure on requester 1; non-owner ready must be ignored
    a.req_valid = 2'b10; a.req_x[1] = 32'h3F800000;
    #1 chk("bp_grant", 32'(a.req_ready), 2);
    cyc(1); a.req_valid = '0;
    cyc(1); a.eng_done = 1'b1; a.eng_fx = 32'h12345678;
    cyc(1); a.eng_done = 1'b0;
    chk("bp_rsp_valid", 32'(a.rsp_valid), 2);
    a.req_valid = 2'b11; a.rsp_ready = 2'b01;
    bad = 0;
    repeat (10) begin
      cyc(1);
      if (a.rsp_valid != 2'b10 || a.rsp_data != 32'h12345678 || a.req_ready != 0 || a.eng_start) bad++;
    end
    chk("bp_hold", bad, 0);
    a.req_valid = '0; a.rsp_ready = 2'b10;
    cyc(1);
    chk("bp_release", 32'(a.rsp_valid), 0);
    a.rsp_ready = '0;
    // one frozen cycle in ISSUE, then asynchronous reset mid-BUSY with a request still pending
    a.req_valid = 2'b01; a.req_x[0] = 32'h40400000;
    #1 chk("rst_test_grant", 32'(a.req_ready), 1);
    cyc(1); clk_en = 1'b0;
    #1 chk("frozen_start", 32'(a.eng_start), 0);
    cyc(1); clk_en = 1'b1;
    #1 chk("resumed_start", 32'(a.eng_start), 1);
    cyc(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_req_ready", 32'(a.req_ready), 0);
    chk("arst_rsp_valid", 32'(a.rsp_valid), 0);
    chk("arst_eng_start", 32'(a.eng_start), 0);
    chk("arst_eng_x", a.eng_x, 0);
    chk("arst_rsp_data", a.rsp_data, 0);
    chk("arst_rsp_err", 32'(a.rsp_err), 0);
    cyc(1); a.req_valid = '0; reset = 1'b0;
    a.eng_done = 1'b1; a.eng_fx = 32'h0BADF00D; a.rsp_ready = 2'b11;
    cyc(1); a.eng_done = 1'b0;
    bad = 0;
    repeat (6) begin
      if (a.rsp_valid != 0 || a.eng_start || a.req_ready != 0) bad++;
      cyc(1);
    end
    chk("arst_no_rsp", bad, 0);
    a.rsp_ready = '0;
    // timeout with a 16-cycle watchdog: response 18 cycles after accept
    b.req_valid = 2'b01; b.req_x[0] = 32'h41200000;
    #1 chk("tmo_grant", 32'(b.req_ready), 1);
    cyc(1); b.req_valid = '0;
    bad = 0;
    for (int c = 1; c <= 17; c++) begin
      if (b.rsp_valid != 0) bad++;
      cyc(1);
    end
    chk("tmo_early", bad, 0);
    chk("tmo_rsp_valid", 32'(b.rsp_valid), 1);
    chk("tmo_rsp_data", b.rsp_data, 32'h7FC00000);
    chk("tmo_rsp_err", 32'(b.rsp_err), 1);
    b.rsp_ready = 2'b01;
    cyc(1); b.rsp_ready = '0;
    chk("tmo_release", 32'(b.rsp_valid), 0);
    b.eng_done = 1'b1; b.eng_fx = 32'hDEADBEEF;
    cyc(1); b.eng_done = 1'b0;
    chk("late_done_valid", 32'(b.rsp_valid), 0);
    chk("late_done_data", b.rsp_data, 32'h7FC00000);
    chk("late_done_start", 32'(b.eng_start), 0);
    // done in the same cycle the watchdog expires (cycle 17) must win
    b.req_valid = 2'b10; b.req_x[1] = 32'h41A00000;
    #1 chk("sim_grant", 32'(b.req_ready), 2);
    cyc(1); b.req_valid = '0;
    cyc(16);
    chk("sim_early", 32'(b.rsp_valid), 0);
    b.eng_done = 1'b1; b.eng_fx = 32'h11223344;
    cyc(1); b.eng_done = 1'b0;
    chk("sim_rsp_valid", 32'(b.rsp_valid), 2);
    chk("sim_rsp_err", 32'(b.rsp_err), 0);
    chk("sim_rsp_data", b.rsp_data, 32'h11223344);
    b.rsp_ready = 2'b10;
    cyc(1); b.rsp_ready = '0;
    // clk_en low for 5 BUSY cycles stretches the timeout from 18 to 23
    b.req_valid = 2'b01; b.req_x[0] = 32'h3F000000;
    #1 chk("en_grant", 32'(b.req_ready), 1);
    cyc(1); b.req_valid = '0;
    cyc(2); clk_en = 1'b0;
    bad = 0;
    repeat (5) begin
      cyc(1);
      if (b.eng_x != 32'h3F000000 || b.rsp_valid != 0 || b.eng_start) bad++;
    end
    clk_en = 1'b1;
    cyc(14);
    chk("en_frozen", bad, 0);
    chk("en_not_yet", 32'(b.rsp_valid), 0);
    chk("en_eng_x", b.eng_x, 32'h3F000000);
    cyc(1);
    chk("en_rsp_valid", 32'(b.rsp_valid), 1);
    chk("en_rsp_err", 32'(b.rsp_err), 1);
    b.rsp_ready = 2'b01;
    cyc(1); b.rsp_ready = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fx_share_arb.md
# fx_share_arb

Round-robin arbiter and sequencer that shares one `fx_opt` evaluation engine, f(x) = x/2 + x²·cos((x−128)/128), between `NUM_REQ` independent requesters, such as a Nios II custom-instruction port and a streaming sample feeder. It captures one request at a time and drives the engine's start/operand pins. It holds the operand stable until the engine reports done, then returns the single-precision result to the owning requester with backpressure. A watchdog converts a hung engine into an error response so that no requester deadlocks.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 256: maximum BUSY cycles allowed before an error response.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clk_en`  in  1  global enable; when low, all registers hold and `eng_start` is forced to 0.
- `req_valid`  in  NUM_REQ  request present, one bit per requester.
- `req_x`  in  NUM_REQ×32  IEEE-754 single operand per requester.
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  one-hot result-valid, held until accepted.
- `rsp_ready`  in  NUM_REQ  requester accepts the result.
- `rsp_data`  out  32  f(x) result, shared by all requesters.
- `rsp_err`  out  1  qualifies `rsp_data` as a timeout error.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_x`  out  32  engine operand, stable from `eng_start` until `eng_done`.
- `eng_done`  in  1  engine result strobe; `eng_fx` is valid in the same cycle.
- `eng_fx`  in  32  engine result.

## Operation
- States: IDLE, ISSUE, BUSY, RESP.
- **IDLE**
  - If any `req_valid` is set, the combinational pick asserts `req_ready[g]` for the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - On accept: latch `req_x[g]` into `x_reg`, latch `g` into `owner`, go to ISSUE.
  - `req_ready` is asserted only in IDLE.
- **ISSUE**
  - Assert `eng_start` for exactly one cycle, clear the watchdog, go to BUSY.
- **BUSY**
  - The watchdog increments each enabled cycle.
  - On `eng_done`: latch `eng_fx` into `rsp_reg`, set `err` = 0, go to RESP.
  - If the watchdog reaches TIMEOUT_CYCLES−1 without `eng_done`: set `rsp_reg` = 32'h7FC00000 (qNaN), set `err` = 1, go to RESP.
  - If `eng_done` and the timeout occur in the same cycle, done wins.
- **RESP**
  - Assert `rsp_valid[owner]`.
  - When `rsp_ready[owner]` is high, set `rr_ptr` = (owner+1) mod NUM_REQ and go to IDLE.
  - `rsp_ready` of non-owners is ignored.
- `eng_done` outside BUSY is ignored and does not alter state; this covers stray or late strobes, including one arriving after a timeout.
- `eng_x` = `x_reg` at all times. The engine operand therefore never changes between ISSUE and the exit from BUSY.
- A `req_valid` drop before acceptance is legal. Once accepted, the request is committed.
- Reset or `clk_en` low mid-operation:
  - Reset aborts immediately: state IDLE, no response issued.
  - `clk_en` low freezes state, `x_reg`, the watchdog and `rr_ptr`.
- No arithmetic is performed on data. The watchdog counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates on the transition.

## Timing
- Reset values:
  - State IDLE, `rr_ptr` = 0, `owner` = 0, `x_reg` = 0, `rsp_reg` = 0, `err` = 0.
  - All `req_ready`, `rsp_valid` and `eng_start` outputs 0.
  - `rsp_data` = 0, `rsp_err` = 0, `eng_x` = 0.
- Accept on cycle 0, `eng_start` on cycle 1, first BUSY cycle is 2.
- With `eng_done` at cycle 1+L (engine latency L ≥ 1), `rsp_valid` rises at cycle 2+L.
- With `rsp_ready` already high, the block returns to IDLE at cycle 3+L, and the next accept is possible that same cycle.
- Back-to-back throughput: one result per L+3 cycles.
- Timeout response: `rsp_valid` rises TIMEOUT_CYCLES+2 cycles after accept.
- `rsp_data`, `rsp_err` and `rsp_valid` are registered and stable while RESP is held.

## Structure
- Package `fx_arb_pkg`:
  - State enum `arb_state_t` {IDLE, ISSUE, BUSY, RESP}.
  - Constant `FX_QNAN` = 32'h7FC00000.
- Sub-module `rr_pick`, parameterised by N, combinational:
  - Inputs `valid[N]` and `ptr`.
  - Outputs one-hot `grant[N]`, `idx` and `any`.
- Top level: state register, datapath registers and watchdog. `fx_opt` is instantiated externally and wired to the `eng_*` pins.

## Test plan
- **Single request.** Requester 0 sends x = 32'h43000000 (128.0), engine model with L = 20. Expect `eng_start` at cycle 1 and `rsp_valid[0]` at cycle 22. Expect `rsp_data` = 32'h46808000 (16448.0) and `rsp_err` = 0.
- **Fairness.** Both requesters valid continuously, each with x = 0. Grants alternate 0,1,0,1 over 4 transactions, and every `rsp_data` = 32'h00000000.
- **Backpressure.** Hold `rsp_ready[1]` low for 10 cycles in RESP. `rsp_valid[1]` and `rsp_data` stay constant, `req_ready` stays 0, and no second `eng_start` occurs.
- **Timeout.** Engine never asserts done, TIMEOUT_CYCLES = 16. Expect `rsp_valid` 18 cycles after accept, `rsp_data` = 32'h7FC00000 and `rsp_err` = 1. A late `eng_done` in IDLE is ignored.
- **Reset and `clk_en`.**
  - Assert reset asynchronously mid-BUSY. All outputs are 0 immediately, and no response is issued afterwards.
  - `clk_en` low for 5 cycles in BUSY stretches the latency by exactly 5 and keeps `eng_x` stable.
- **Simultaneous events.** `eng_done` on the same cycle as the watchdog limit yields `rsp_err` = 0 with `rsp_data` = `eng_fx`.
